// File: rtl/mem_bist_ctrl_if.sv
// rtl/mem_bist_ctrl_if.sv - DataMemory port bundle between the BIST initiator and the memory
interface mem_bist_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_read_write,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_read_write,
        output mem_read_data
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - memory BIST initiator: incrementing-pattern write pass then read/compare pass
module mem_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    count,
    input  logic [DATA_W-1:0]    seed,
    mem_bist_ctrl_if.master      mem,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_expected,
    output logic [DATA_W-1:0]    fail_actual
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [7:0]        ERR_ONE  = 8'd1;
    localparam logic [7:0]        ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] pattern;
    logic              last;
    logic              mismatch;
    logic [7:0]        err_next;

    assign last     = (idx == count_q - ADDR_ONE);
    assign pattern  = seed_q + DATA_W'(idx);
    assign mismatch = (state == READ) && (mem.mem_read_data != pattern);
    assign err_next = (mismatch && err_count != ERR_MAX) ? err_count + ERR_ONE : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-side outputs decode only registered state, so reset drops a write immediately.
    always_comb begin
        state_next          = state;
        busy                = 1'b1;
        done                = 1'b0;
        mem.mem_read_write  = 1'b0;
        mem.mem_address     = '0;
        mem.mem_write_data  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (count == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                mem.mem_read_write = 1'b1;
                mem.mem_address    = base_q + idx;
                mem.mem_write_data = pattern;
                if (last) begin
                    state_next = READ;
                end
            end
            READ: begin
                mem.mem_address = base_q + idx;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            base_q        <= '0;
            count_q       <= '0;
            seed_q        <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        count_q       <= count;
                        seed_q        <= seed;
                        idx           <= '0;
                        err_count     <= '0;
                        pass          <= (count == '0);
                        fail_addr     <= '0;
                        fail_expected <= '0;
                        fail_actual   <= '0;
                    end
                end
                WRITE: begin
                    idx <= last ? '0 : idx + ADDR_ONE;
                end
                READ: begin
                    idx       <= last ? '0 : idx + ADDR_ONE;
                    err_count <= err_next;
                    // err_count still zero means this is the first mismatch of the run.
                    if (mismatch && err_count == '0) begin
                        fail_addr     <= base_q + idx;
                        fail_expected <= pattern;
                        fail_actual   <= mem.mem_read_data;
                    end
                    if (last) begin
                        pass <= (err_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - scoreboard bench for mem_bist_ctrl with a behavioural memory and run model
module tb_mem_bist_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] count;
    logic [7:0] seed;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] fail_addr;
    logic [7:0] fail_expected;
    logic [7:0] fail_actual;

    mem_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .seed          (seed),
        .mem           (bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       fault_en;
    logic       fault_all;
    logic [7:0] fault_addr;
    logic [7:0] fault_val;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic [7:0] errs;
        logic [7:0] fa;
        logic [7:0] fe;
        logic [7:0] fact;
    } res_t;

    acc_t acc_q[$];
    res_t res_q[$];

    // Memory with injectable read faults
    assign bus.mem_read_data = fault_all ? ~mem[bus.mem_address]
                             : (fault_en && bus.mem_address == fault_addr) ? fault_val
                             : mem[bus.mem_address];

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h5A;
        forever begin
            @(posedge clk);
            if (bus.mem_read_write === 1'b1) mem[bus.mem_address] <= bus.mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (fault_all) return ~ref_mem[a];
        if (fault_en && a == fault_addr) return fault_val;
        return ref_mem[a];
    endfunction

    // Whole-run model: write window, read it back, tally mismatches; ref_cyc is cycle 0 of the run.
    task automatic model_run(input logic [7:0] b, input logic [7:0] c, input logic [7:0] s,
                             input int ref_cyc);
        res_t       r;
        acc_t       e;
        logic [7:0] a;
        logic [7:0] ex;
        logic [7:0] rd;
        int         errs = 0;
        r.fa = 8'h00; r.fe = 8'h00; r.fact = 8'h00;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 8'(i);
            ref_mem[a] = s + 8'(i);
            e.rw = 1'b1; e.addr = a; e.data = s + 8'(i);
            acc_q.push_back(e);
        end
        for (int i = 0; i < int'(c); i++) begin
            a  = b + 8'(i);
            ex = s + 8'(i);
            rd = model_read(a);
            e.rw = 1'b0; e.addr = a; e.data = 8'h00;
            acc_q.push_back(e);
            if (rd !== ex) begin
                if (errs == 0) begin
                    r.fa = a; r.fe = ex; r.fact = rd;
                end
                errs++;
            end
        end
        r.errs     = (errs > 255) ? 8'hFF : 8'(errs);
        r.pass     = (errs == 0);
        r.done_cyc = ref_cyc + 2 * int'(c) + 1;
        res_q.push_back(r);
    endtask

    // Monitor: pops expected accesses while busy, expected results on done
    initial begin
        acc_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (!busy) begin
                    chk("idle_rw", bus.mem_read_write, 0);
                    chk("idle_addr", bus.mem_address, 0);
                    chk("idle_wdata", bus.mem_write_data, 0);
                end else if (done) begin
                    chk("done_rw", bus.mem_read_write, 0);
                    if (res_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        r = res_q.pop_front();
                        chk("done_cycle", cyc, r.done_cyc);
                        chk("pass", pass, r.pass);
                        chk("err_count", err_count, r.errs);
                        chk("fail_addr", fail_addr, r.fa);
                        chk("fail_expected", fail_expected, r.fe);
                        chk("fail_actual", fail_actual, r.fact);
                    end
                end else begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_access", 1, 0);
                    end else begin
                        e = acc_q.pop_front();
                        chk("access_rw", bus.mem_read_write, e.rw);
                        chk("access_addr", bus.mem_address, e.addr);
                        if (e.rw) chk("access_wdata", bus.mem_write_data, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic run(input logic [7:0] b, input logic [7:0] c, input logic [7:0] s);
        @(negedge clk);
        start = 1'b1; base_addr = b; count = c; seed = s;
        model_run(b, c, s, cyc);
        @(negedge clk);
        start = 1'b0;
        base_addr = 8'($urandom); count = 8'($urandom); seed = 8'($urandom);
        wait_idle(600);
    endtask

    task automatic backdoor(input string name);
        int nbad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) nbad++;
        chk(name, nbad, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_faddr"}, fail_addr, 0);
        chk({tag, "_fexp"}, fail_expected, 0);
        chk({tag, "_fact"}, fail_actual, 0);
        chk({tag, "_rw"}, bus.mem_read_write, 0);
        chk({tag, "_addr"}, bus.mem_address, 0);
        chk({tag, "_wdata"}, bus.mem_write_data, 0);
    endtask

    initial begin
        int ref1;
        int ref2;
        int n;
        acc_t e;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0;
        fault_en = 1'b0; fault_all = 1'b0; fault_addr = '0; fault_val = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'h5A;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        run(8'h00, 8'd10, 8'h00);
        backdoor("basic_mem");
        chk("basic_pass", pass, 1);
        chk("basic_err", err_count, 0);

        run(8'hFA, 8'd10, 8'h80);
        backdoor("wrap_mem");
        chk("wrap_pass", pass, 1);
        chk("wrap_addr04_untouched", mem[4], 8'h04);

        fault_en = 1'b1; fault_addr = 8'h04; fault_val = 8'h04;
        run(8'h00, 8'd8, 8'h01);
        fault_en = 1'b0;
        chk("fault_pass", pass, 0);
        chk("fault_err", err_count, 1);
        chk("fault_addr", fail_addr, 8'h04);
        chk("fault_expected", fail_expected, 8'h05);
        chk("fault_actual", fail_actual, 8'h04);
        backdoor("fault_mem");

        run(8'h33, 8'd0, 8'h77);
        chk("empty_pass", pass, 1);
        backdoor("empty_mem");

        // Reset during WRITE with i=3: only the first three words may land
        @(negedge clk);
        start = 1'b1; base_addr = 8'h10; count = 8'd8; seed = 8'h20;
        for (int i = 0; i < 4; i++) begin
            e.rw = 1'b1; e.addr = 8'h10 + 8'(i); e.data = 8'h20 + 8'(i);
            acc_q.push_back(e);
            if (i < 3) ref_mem[8'h10 + 8'(i)] = 8'h20 + 8'(i);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_rw", bus.mem_read_write, 0);
        @(negedge clk);
        check_reset("midrun");
        rst = 1'b0;
        backdoor("midrun_mem");
        chk("midrun_acc_drained", acc_q.size(), 0);

        // Start pulsed during READ is ignored; start held through DONE relaunches after one IDLE cycle
        @(negedge clk);
        start = 1'b1; base_addr = 8'h30; count = 8'd6; seed = 8'h40;
        ref1 = cyc;
        model_run(8'h30, 8'd6, 8'h40, ref1);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b1; base_addr = 8'h90; count = 8'd3; seed = 8'h11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 8'hA0; count = 8'd4; seed = 8'h55;
        ref2 = ref1 + 2 * 6 + 2;
        model_run(8'hA0, 8'd4, 8'h55, ref2);
        n = 0;
        while (cyc < ref2 + 1 && n < 100) begin
            @(negedge clk);
            n++;
            if (cyc == ref2) chk("b2b_idle_gap", busy, 0);
        end
        chk("b2b_started", busy, 1);
        start = 1'b0;
        wait_idle(100);
        backdoor("b2b_mem");

        for (int r = 0; r < 16; r++) begin
            fault_all  = ($urandom_range(0, 5) == 0);
            fault_en   = 1'($urandom_range(0, 1));
            fault_addr = 8'($urandom);
            fault_val  = 8'($urandom);
            run(8'($urandom), 8'($urandom_range(0, 24)), 8'($urandom));
        end
        fault_all = 1'b0; fault_en = 1'b0;
        backdoor("random_mem");

        fault_all = 1'b1;
        run(8'($urandom), 8'd255, 8'($urandom));
        fault_all = 1'b0;
        chk("full_err", err_count, 8'd255);
        chk("full_pass", pass, 0);
        backdoor("full_mem");

        chk("acc_q_empty", acc_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
